// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, default timing and parity helper.
package ps2_pkg;

    localparam int unsigned PS2_INHIBIT_CYCLES = 2500;
    localparam int unsigned PS2_TIMEOUT_CYCLES = 375000;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line plus falling-edge detect on the synchronized level.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    // Idle PS/2 lines are pulled high, so every stage resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-keyboard PS/2 byte transmitter with inhibit, open-drain line control and timeout.
//
// state     | meaning
// IDLE      | lines released, ready for a byte
// INHIBIT   | clock held low for INHIBIT_CYCLES
// START     | clock released, data low (start bit), waiting for device clock
// DATA      | presenting data bit idx
// PARITY    | presenting odd parity bit
// STOP      | data released (stop bit)
// ACK       | waiting for the device acknowledge edge
// WAIT_IDLE | waiting for both lines to return high
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_N_In,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Valid,
    output logic       Tx_Ready,
    output logic       Tx_Done,
    output logic       Tx_Error,
    input  logic       PS2_CLK_In,
    input  logic       PS2_DATA_In,
    output logic       PS2_CLK_Oe,
    output logic       PS2_DATA_Oe
);

    localparam int unsigned MAX_CYCLES = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    logic clk_level, clk_fall, data_level, data_fall;

    ps2_sync_edge u_sync_clk (
        .clk     (Master_Clock_In),
        .rst_n   (Reset_N_In),
        .line_in (PS2_CLK_In),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_sync_edge u_sync_data (
        .clk     (Master_Clock_In),
        .rst_n   (Reset_N_In),
        .line_in (PS2_DATA_In),
        .level   (data_level),
        .fall    (data_fall)
    );

    ps2_tx_state_e state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic          parity_q, parity_d;
    logic [2:0]    idx_q, idx_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        idx_d     = idx_q;
        timer_d   = (timer_q != '0) ? timer_q - CNT_W'(1) : timer_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (Tx_Valid) begin
                    byte_d   = Tx_Data;
                    parity_d = odd_parity(Tx_Data);
                    timer_d  = CNT_W'(INHIBIT_CYCLES - 1);
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == '0) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    timer_d   = CNT_W'(TIMEOUT_CYCLES - 1);
                    state_d   = START;
                end
            end
            START: begin
                if (clk_fall) begin
                    idx_d     = 3'd0;
                    data_oe_d = ~byte_q[0];
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    if (idx_q == 3'd7) begin
                        data_oe_d = ~parity_q;
                        state_d   = PARITY;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        data_oe_d = ~byte_q[idx_q + 3'd1];
                    end
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    data_oe_d = 1'b0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (clk_fall) state_d = ACK;
            end
            ACK: begin
                if (clk_fall) begin
                    if (!data_level) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A device clock edge restarts the watchdog; expiry overrides whatever the case decided.
        if (state_q inside {START, DATA, PARITY, STOP, ACK, WAIT_IDLE}) begin
            if (clk_fall) begin
                timer_d = CNT_W'(TIMEOUT_CYCLES - 1);
            end else if (timer_q == '0) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b0;
                error_d   = 1'b1;
                state_d   = IDLE;
            end
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            parity_q  <= 1'b0;
            idx_q     <= '0;
            timer_q   <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            parity_q  <= parity_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign Tx_Ready    = ready_q;
    assign Tx_Done     = done_q;
    assign Tx_Error    = error_q;
    assign PS2_CLK_Oe  = clk_oe_q;
    assign PS2_DATA_Oe = data_oe_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: keyboard model on open-drain lines, scoreboard of expected frames.
module tb_ps2_transmitter;

    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, clk_oe, data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(clk_oe | dev_clk_low);
    assign ps2_data = ~(data_oe | dev_data_low);

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic ready_at_done = 1'b0;
    logic [9:0] exp_q[$];

    ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .Master_Clock_In (clk),
        .Reset_N_In      (rst_n),
        .Tx_Data         (tx_data),
        .Tx_Valid        (tx_valid),
        .Tx_Ready        (tx_ready),
        .Tx_Done         (tx_done),
        .Tx_Error        (tx_error),
        .PS2_CLK_In      (ps2_clk),
        .PS2_DATA_In     (ps2_data),
        .PS2_CLK_Oe      (clk_oe),
        .PS2_DATA_Oe     (data_oe)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) begin
            done_cnt++;
            ready_at_done = tx_ready;
        end
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) begin
            failures++;
            $error("FAIL done_and_error observed=1 expected=0");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back(frame_of(b));
        @(negedge clk);
        tx_valid = 1'b0;
        chk("ready_low_after_accept", tx_ready, 0);
    endtask

    task automatic wait_request(output int inh, output bit ok);
        inh = 0;
        for (int n = 0; n < 100 && !clk_oe; n++) @(negedge clk);
        while (clk_oe && inh < 1000) begin
            inh++;
            @(negedge clk);
        end
        ok = !clk_oe && data_oe;
    endtask

    task automatic kb_clock(output logic smp);
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        smp = ps2_data;
        dev_clk_low = 1'b0;
    endtask

    task automatic kb_frame(input int nclk, input bit ack, output logic [9:0] bits);
        logic s;
        bits = '0;
        for (int k = 0; k < nclk; k++) begin
            kb_clock(s);
            if (k < 10) bits[k] = s;
            if (k == 10 && ack) dev_data_low = 1'b1;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic full_frame(input logic [7:0] b, input string tag);
        int inh;
        bit ok;
        int d0, e0;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        wait_request(inh, ok);
        chk({tag, "_inhibit_cycles"}, inh, INH);
        chk({tag, "_start_bit"}, ok, 1);
        kb_frame(12, 1'b1, bits);
        repeat (10) @(negedge clk);
        chk({tag, "_frame_bits"}, bits, exp_q.pop_front());
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_error_pulses"}, err_cnt - e0, 0);
        chk({tag, "_ready_after"}, tx_ready, 1);
    endtask

    initial begin
        int inh, n, d0, e0;
        bit ok;
        logic [9:0] bits;
        logic [9:0] discard;

        #5 rst_n = 1'b0;
        #1;
        chk("reset_ready", tx_ready, 1);
        chk("reset_oe", {clk_oe, data_oe}, 0);
        chk("reset_pulses", {tx_done, tx_error}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Known frame for 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
        chk("ed_expected_frame", frame_of(8'hED), 10'b11_1110_1101);
        full_frame(8'hED, "ed");
        full_frame(8'h01, "x01");
        full_frame(8'h00, "x00");
        chk("parity_x01_x00", {frame_of(8'h01)[8], frame_of(8'h00)[8]}, 2'b01);

        // Device stops clocking after bit 3.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hA5);
        discard = exp_q.pop_front();
        wait_request(inh, ok);
        kb_frame(4, 1'b0, bits);
        n = 0;
        while (!tx_error && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency_window", (n + HALF >= TMO && n + HALF <= TMO + 6), 1);
        chk("timeout_oe_released", {clk_oe, data_oe}, 0);
        chk("timeout_ready", tx_ready, 1);
        repeat (5) @(negedge clk);
        chk("timeout_error_pulses", err_cnt - e0, 1);
        chk("timeout_done_pulses", done_cnt - d0, 0);
        chk("timeout_bits_low_nibble", bits[3:0], 4'h5);

        // Device withholds the acknowledge.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h3C);
        wait_request(inh, ok);
        kb_frame(12, 1'b0, bits);
        repeat (10) @(negedge clk);
        chk("noack_frame_bits", bits, exp_q.pop_front());
        chk("noack_error_pulses", err_cnt - e0, 1);
        chk("noack_done_pulses", done_cnt - d0, 0);
        chk("noack_ready", tx_ready, 1);

        // Reset in the middle of DATA.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h00);
        discard = exp_q.pop_front();
        wait_request(inh, ok);
        kb_frame(3, 1'b0, bits);
        chk("midreset_pre_data_oe", data_oe, 1);
        #5 rst_n = 1'b0;
        #1;
        chk("midreset_oe_immediate", {clk_oe, data_oe}, 0);
        chk("midreset_ready_immediate", tx_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("midreset_no_pulses", {done_cnt - d0, err_cnt - e0}, 0);
        full_frame(8'hFF, "ff");

        // Valid held high across a frame while the data input changes.
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        exp_q.push_back(frame_of(8'h5A));
        @(negedge clk);
        chk("hold_ready_low", tx_ready, 0);
        wait_request(inh, ok);
        tx_data = 8'hC3;
        exp_q.push_back(frame_of(8'hC3));
        chk("hold_ready_low_midframe", tx_ready, 0);
        kb_frame(12, 1'b1, bits);
        chk("hold_first_bits", bits, exp_q.pop_front());
        wait_request(inh, ok);
        tx_valid = 1'b0;
        chk("hold_first_done", done_cnt - d0, 1);
        chk("hold_ready_at_done", ready_at_done, 1);
        chk("hold_second_inhibit", inh, INH);
        kb_frame(12, 1'b1, bits);
        repeat (10) @(negedge clk);
        chk("hold_second_bits", bits, exp_q.pop_front());
        chk("hold_total_done", done_cnt - d0, 2);
        chk("hold_no_errors", err_cnt - e0, 0);
        repeat (10) @(negedge clk);
        chk("hold_no_third_frame", {clk_oe, tx_ready}, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_transmitter.md
PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 Clocking SHALL be one clock with an asynchronous, active-low reset: Master_Clock_In (25 MHz system clock) and Reset_N_In.
REQ-002 Parameter INHIBIT_CYCLES, 2500, number of cycles the clock line is held low before the request (100 us at 25 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, 375000, maximum number of cycles between device clock falling edges (15 ms).
REQ-004 Master_Clock_In  in  1  system clock.
REQ-005 Reset_N_In  in  1  asynchronous active-low reset.
REQ-006 Tx_Data  in  8  byte to send to the keyboard.
REQ-007 Tx_Valid  in  1  send request, qualified by Tx_Ready.
REQ-008 Tx_Ready  out  1  high only in IDLE.
REQ-009 Tx_Done  out  1  one-cycle pulse on a successful, acknowledged transfer.
REQ-010 Tx_Error  out  1  one-cycle pulse on a timeout or missing acknowledge.
REQ-011 PS2_CLK_In  in  1  raw keyboard clock line level.
REQ-012 PS2_DATA_In  in  1  raw keyboard data line level.
REQ-013 PS2_CLK_Oe  out  1  1 = drive the clock line low; 0 = release it (open-drain).
REQ-014 PS2_DATA_Oe  out  1  1 = drive the data line low; 0 = release it (open-drain).

Function
REQ-015 PS2_CLK_In and PS2_DATA_In SHALL each pass through a 2-FF synchronizer; a falling edge SHALL be detected as synchronized previous=1 and current=0.
REQ-016 States SHALL be IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK and WAIT_IDLE.
REQ-017 IDLE: both Oe outputs are 0 and Tx_Ready=1; when Tx_Valid=1 the block latches Tx_Data, computes odd parity (~^Tx_Data) and enters INHIBIT on the next cycle, with Tx_Ready=0 from that cycle.
REQ-018 INHIBIT: PS2_CLK_Oe=1 and PS2_DATA_Oe=0 for exactly INHIBIT_CYCLES cycles, then the block enters START.
REQ-019 START: PS2_CLK_Oe=0 and PS2_DATA_Oe=1 (start bit); on a falling edge the block drives bit 0 and enters DATA with the bit index at 0.
REQ-020 DATA: PS2_DATA_Oe equals ~Tx_Data[idx]; each falling edge increments idx; the falling edge seen at idx=7 drives the parity bit and enters PARITY.
REQ-021 PARITY: PS2_DATA_Oe equals ~parity; a falling edge releases data (stop bit) and enters STOP.
REQ-022 STOP: PS2_DATA_Oe=0; a falling edge enters ACK.
REQ-023 ACK: on the next falling edge, synchronized data=0 enters WAIT_IDLE; data=1 pulses Tx_Error and enters IDLE.
REQ-024 WAIT_IDLE: when synchronized clock and data are both 1, the block pulses Tx_Done and enters IDLE.
REQ-025 Timeout counter: cleared on entry to START and on every falling edge; if it reaches TIMEOUT_CYCLES in START through WAIT_IDLE, both Oe outputs are released, Tx_Error pulses for one cycle, and the block enters IDLE.
REQ-026 Tx_Valid asserted while Tx_Ready=0 SHALL be ignored and not queued.
REQ-027 Tx_Done and Tx_Error SHALL never assert in the same cycle.
REQ-028 The latched byte SHALL be unaffected by changes to Tx_Data after acceptance.

Reset
REQ-029 Reset_N_In=0 SHALL immediately force IDLE, both Oe outputs to 0, Tx_Ready=1, Tx_Done=0, Tx_Error=0, and clear all counters and synchronizers (synchronizers to 1), including in the middle of a frame.
REQ-030 After a mid-frame reset, no Tx_Done or Tx_Error pulse SHALL be produced for the aborted frame.

Structure
REQ-031 The state encodings and the default INHIBIT_CYCLES and TIMEOUT_CYCLES values SHALL live in a shared package ps2_pkg, which PS2Receiver may also use.
REQ-032 Synchronization and falling-edge detection SHALL be one sub-module, ps2_sync_edge, instantiated once per line.
REQ-033 The 25 MHz clock domain SHALL be the only clock; no logic SHALL be clocked by PS2_CLK_In.

Verification (bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, and a keyboard model that clocks on request and acknowledges)
REQ-034 Send 0xED -> clock held low 20 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop released; ack sampled; one Tx_Done pulse; Tx_Ready returns to 1.
REQ-035 Send 0x01 and 0x00 -> parity bits 0 and 1 respectively; each ends with Tx_Done.
REQ-036 Model stops clocking after bit 3 -> Tx_Error pulses 200 cycles after the last falling edge; both Oe outputs are 0; the block is in IDLE.
REQ-037 Model omits the acknowledge (data high at the ack edge) -> Tx_Error pulse and no Tx_Done.
REQ-038 Reset asserted during DATA -> Oe outputs are 0 in the same cycle; no pulses; a following send of 0xFF completes with parity 1.
REQ-039 Tx_Valid held high through a frame with Tx_Data changed mid-frame -> only the latched byte is sent, and a second frame starts only after Tx_Ready returns to 1.
